spike_window_decoder: RTL and testbench
=======================================

SPIKE_WINDOW_DECODER -- requirements
Module: spike_window_decoder

Interface
REQ-001: Parameter WIN_LEN, default 8: number of clock cycles spikes are counted per classification window (legal 1..255).
REQ-002: Parameter CNT_W, default 4: width of each per-neuron saturating spike counter.
REQ-003: clock  input  1  single system clock; all state updates on posedge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: spk_in  input  3  output-layer spikes {outp_1,outp_2,outp_3}; spk_in[2]=neuron 1, spk_in[0]=neuron 3.
REQ-006: start  input  1  one-cycle request to open a new classification window.
REQ-007: exp_label  input  3  expected one-hot class; sampled only when start is accepted.
REQ-008: res_valid  output  1  result available; held until handshake completes.
REQ-009: res_ready  input  1  consumer accepts result when high together with res_valid.
REQ-010: result  output  3  one-hot winning neuron, same bit order as spk_in; 3'b000 = undecided.
REQ-011: busy  output  1  high in every state except IDLE.
REQ-012: overrun  output  1  sticky flag: a start was dropped.
REQ-013: match_cnt  output  8  number of windows where result equalled a non-zero exp_label.
REQ-014: trial_cnt  output  8  number of completed windows.

Function
REQ-015: FSM states SHALL be IDLE, COLLECT, DECIDE, HOLD.
REQ-016: In IDLE, start=1 SHALL clear all three counters, latch exp_label and move to COLLECT on that edge; the spk_in value on the start cycle is not counted.
REQ-017: In COLLECT, each counter SHALL increment by one on every edge where its spk_in bit is 1, saturating at 2^CNT_W-1.
REQ-018: COLLECT SHALL last exactly WIN_LEN edges, tracked by an 8-bit window counter, then move to DECIDE.
REQ-019: DECIDE SHALL last one cycle: result = one-hot of the strictly largest count; all counts zero, or two or more counts sharing the maximum, SHALL give 3'b000.
REQ-020: On leaving DECIDE, trial_cnt SHALL increment; match_cnt SHALL increment only if result equals the latched exp_label and that label is non-zero; both saturate at 255.
REQ-021: res_valid SHALL be 1 exactly while in HOLD; HOLD is entered on edge WIN_LEN+2 counted from the start edge (edge 0).
REQ-022: In HOLD, result SHALL stay stable until res_valid&res_ready on an edge; the FSM then goes to IDLE, or directly to COLLECT if start is also 1 on that edge (start accepted, no overrun).
REQ-023: A start in COLLECT, DECIDE, or in HOLD without res_ready SHALL be ignored and SHALL set overrun.
REQ-024: exp_label changes outside an accepted start SHALL have no effect.

Reset
REQ-025: reset=1 SHALL, asynchronously, force IDLE and zero the counters, result, res_valid, busy, overrun, match_cnt and trial_cnt, including mid-window.
REQ-026: After reset deasserts, the first start SHALL be accepted on the next edge.

Structure
REQ-027: The state encoding localparams and the default WIN_LEN/CNT_W values SHALL live in the shared SNN package/include, snn_decode_pkg.
REQ-028: The per-neuron saturating counter SHALL be a sub-module, spike_sat_counter, with ports clock, reset, clr, inc and cnt. It is instantiated three times.

Verification (WIN_LEN=8, CNT_W=4)
REQ-029: Reset, then 10 idle cycles -> all outputs 0 and busy=0.
REQ-030: start with exp_label=100; spk_in=100 for 5 cycles, 010 for 2, 000 for 1 -> counts 5/2/0, result=100, res_valid rises 10 edges after start, match_cnt=1, trial_cnt=1.
REQ-031: spk_in=110 for all 8 cycles, exp_label=100 -> result=000, match_cnt unchanged, trial_cnt +1.
REQ-032: WIN_LEN=20, spk_in=001 every cycle, exp_label=001 -> counter 3 saturates at 15, result=001, match_cnt +1.
REQ-033: start pulsed at COLLECT cycle 3 -> ignored, overrun=1, window length unchanged. A separate run asserts reset mid-COLLECT -> res_valid=0, busy=0, counters 0 immediately.
REQ-034: res_ready held low 5 cycles in HOLD -> result and res_valid stable. Then res_ready=1 with start=1 on the same edge -> new COLLECT begins, busy stays 1, overrun stays 0.

Source files
------------

// File: rtl/snn_decode_pkg.sv
// Shared definitions for the output-layer spike decoder: default window/counter
// sizes, FSM state encoding and the winner-selection helper.
package snn_decode_pkg;

  localparam int DEF_WIN_LEN = 8;
  localparam int DEF_CNT_W   = 4;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_COLLECT_ENC = 2'd1;
  localparam logic [1:0] ST_DECIDE_ENC  = 2'd2;
  localparam logic [1:0] ST_HOLD_ENC    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_COLLECT = ST_COLLECT_ENC,
    ST_DECIDE  = ST_DECIDE_ENC,
    ST_HOLD    = ST_HOLD_ENC
  } state_e;

  // One-hot of the strictly largest count; ties at the maximum (including all zero) give 3'b000.
  function automatic logic [2:0] pick_winner(input logic [15:0] c1,
                                             input logic [15:0] c2,
                                             input logic [15:0] c3);
    logic [2:0] w;
    w = 3'b000;
    if (c1 > c2 && c1 > c3)      w = 3'b100;
    else if (c2 > c1 && c2 > c3) w = 3'b010;
    else if (c3 > c1 && c3 > c2) w = 3'b001;
    return w;
  endfunction

endpackage

// File: rtl/spike_sat_counter.sv
// Per-neuron spike counter: synchronous clear, increment that saturates at all-ones.
module spike_sat_counter
  import snn_decode_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                        cnt_d = '0;
    else if (inc && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/spike_window_decoder.sv
// Counts output-layer spikes over a fixed window, picks the unique winner and
// offers it on a valid/ready result port while keeping match/trial statistics.
module spike_window_decoder
  import snn_decode_pkg::*;
#(
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         spk_in,
  input  logic               start,
  input  logic [2:0]         exp_label,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2:0]         result,
  output logic               busy,
  output logic               overrun,
  output logic [7:0]         match_cnt,
  output logic [7:0]         trial_cnt,
  output logic [1:0]         dbg_state,
  output logic [3*CNT_W-1:0] dbg_cnt
);

  // Result handshake: result is offered while res_valid is high and is
  // consumed on a rising edge where res_valid and res_ready are both 1.
  localparam logic [7:0] WIN_LAST = 8'(WIN_LEN);

  state_e     state_q, state_d;
  logic [7:0] win_q, win_d;
  logic [2:0] label_q, label_d;
  logic [2:0] result_q, result_d;
  logic [7:0] match_q, match_d;
  logic [7:0] trial_q, trial_d;
  logic       overrun_q, overrun_d;
  logic       busy_q, busy_d;
  logic       valid_q, valid_d;

  logic             clr, inc_en;
  logic [2:0]       winner;
  logic [CNT_W-1:0] cnt1, cnt2, cnt3;

  spike_sat_counter #(.CNT_W(CNT_W)) u_cnt1 (
    .clock(clock), .reset(reset), .clr(clr), .inc(inc_en & spk_in[2]), .cnt(cnt1));
  spike_sat_counter #(.CNT_W(CNT_W)) u_cnt2 (
    .clock(clock), .reset(reset), .clr(clr), .inc(inc_en & spk_in[1]), .cnt(cnt2));
  spike_sat_counter #(.CNT_W(CNT_W)) u_cnt3 (
    .clock(clock), .reset(reset), .clr(clr), .inc(inc_en & spk_in[0]), .cnt(cnt3));

  assign winner = pick_winner(16'(cnt1), 16'(cnt2), 16'(cnt3));

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    label_d   = label_q;
    result_d  = result_q;
    match_d   = match_q;
    trial_d   = trial_q;
    overrun_d = overrun_q;
    clr       = 1'b0;
    inc_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          label_d = exp_label;
          win_d   = 8'd0;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (start) overrun_d = 1'b1;
        // WIN_LEN counting edges, then one edge to hand over to DECIDE.
        if (win_q == WIN_LAST) begin
          state_d = ST_DECIDE;
        end else begin
          inc_en = 1'b1;
          win_d  = win_q + 8'd1;
        end
      end
      ST_DECIDE: begin
        if (start) overrun_d = 1'b1;
        result_d = winner;
        if (trial_q != 8'hFF) trial_d = trial_q + 8'd1;
        if (winner == label_q && label_q != 3'b000 && match_q != 8'hFF)
          match_d = match_q + 8'd1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) begin
          result_d = 3'b000;
          if (start) begin
            clr     = 1'b1;
            label_d = exp_label;
            win_d   = 8'd0;
            state_d = ST_COLLECT;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (start) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      win_q     <= 8'd0;
      label_q   <= 3'b000;
      result_q  <= 3'b000;
      match_q   <= 8'd0;
      trial_q   <= 8'd0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      label_q   <= label_d;
      result_q  <= result_d;
      match_q   <= match_d;
      trial_q   <= trial_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign res_valid = valid_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign match_cnt = match_q;
  assign trial_cnt = trial_q;
  assign dbg_state = state_q;
  assign dbg_cnt   = {cnt1, cnt2, cnt3};

endmodule

// File: tb/tb_spike_window_decoder.sv
// Directed bench for spike_window_decoder: default-size instance for most
// scenarios plus a WIN_LEN=20 instance for counter saturation.
module tb_spike_window_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic [2:0]  spk_in = '0, exp_label = '0, result;
  logic        start = 1'b0, res_ready = 1'b0;
  logic        res_valid, busy, overrun;
  logic [7:0]  match_cnt, trial_cnt;
  logic [1:0]  dbg_state;
  logic [11:0] dbg_cnt;

  logic [2:0]  spk2 = '0, exp2 = '0, result2;
  logic        start2 = 1'b0, ready2 = 1'b0;
  logic        valid2, busy2, overrun2;
  logic [7:0]  match2, trial2;
  logic [1:0]  state2;
  logic [11:0] cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  spike_window_decoder #(.WIN_LEN(8), .CNT_W(4)) u_dut (
    .clock(clock), .reset(reset), .spk_in(spk_in), .start(start),
    .exp_label(exp_label), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .busy(busy), .overrun(overrun), .match_cnt(match_cnt),
    .trial_cnt(trial_cnt), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt));

  spike_window_decoder #(.WIN_LEN(20), .CNT_W(4)) u_dut20 (
    .clock(clock), .reset(reset), .spk_in(spk2), .start(start2),
    .exp_label(exp2), .res_valid(valid2), .res_ready(ready2),
    .result(result2), .busy(busy2), .overrun(overrun2), .match_cnt(match2),
    .trial_cnt(trial2), .dbg_state(state2), .dbg_cnt(cnt2));

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset and idle
    reset = 1'b1;
    step(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    reset = 1'b0;
    step(10);
    check("idle_result", 32'(result), 32'd0);
    check("idle_valid", 32'(res_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_overrun", 32'(overrun), 32'd0);
    check("idle_match", 32'(match_cnt), 32'd0);
    check("idle_trial", 32'(trial_cnt), 32'd0);
    check("idle_cnt", 32'(dbg_cnt), 32'h000);

    // Window 1: neuron 1 wins, label matches
    start = 1'b1; exp_label = 3'b100; spk_in = 3'b111;
    step(1);
    check("w1_busy", 32'(busy), 32'd1);
    start = 1'b0; exp_label = 3'b001; spk_in = 3'b100;
    step(5);
    spk_in = 3'b010;
    step(2);
    spk_in = 3'b000;
    step(1);
    check("w1_counts", 32'(dbg_cnt), 32'h520);
    check("w1_valid_e8", 32'(res_valid), 32'd0);
    step(1);
    check("w1_valid_e9", 32'(res_valid), 32'd0);
    step(1);
    check("w1_valid_e10", 32'(res_valid), 32'd1);
    check("w1_result", 32'(result), 32'h4);
    check("w1_match", 32'(match_cnt), 32'd1);
    check("w1_trial", 32'(trial_cnt), 32'd1);
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    check("w1_rel_valid", 32'(res_valid), 32'd0);
    check("w1_rel_busy", 32'(busy), 32'd0);

    // Window 2: tie between neurons 1 and 2
    start = 1'b1; exp_label = 3'b100; spk_in = 3'b000;
    step(1);
    start = 1'b0; spk_in = 3'b110;
    step(8);
    spk_in = 3'b000;
    check("w2_counts", 32'(dbg_cnt), 32'h880);
    step(2);
    check("w2_valid", 32'(res_valid), 32'd1);
    check("w2_result", 32'(result), 32'h0);
    check("w2_match", 32'(match_cnt), 32'd1);
    check("w2_trial", 32'(trial_cnt), 32'd2);
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;

    // Window 3: neuron 3 wins, then a stalled consumer
    start = 1'b1; exp_label = 3'b001;
    step(1);
    start = 1'b0; spk_in = 3'b001;
    step(8);
    spk_in = 3'b000;
    step(2);
    check("w3_match", 32'(match_cnt), 32'd2);
    check("w3_trial", 32'(trial_cnt), 32'd3);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("w3_hold_valid", 32'(res_valid), 32'd1);
      check("w3_hold_result", 32'(result), 32'h1);
    end
    // Release and restart on the same edge
    res_ready = 1'b1; start = 1'b1; exp_label = 3'b010;
    step(1);
    res_ready = 1'b0; start = 1'b0; exp_label = 3'b100;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_valid", 32'(res_valid), 32'd0);
    check("b2b_overrun", 32'(overrun), 32'd0);
    check("b2b_state", 32'(dbg_state), 32'd1);
    check("b2b_cnt", 32'(dbg_cnt), 32'h000);

    // Window 4: dropped start mid-collect
    spk_in = 3'b010;
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    spk_in = 3'b000;
    check("w4_overrun", 32'(overrun), 32'd1);
    check("w4_counts", 32'(dbg_cnt), 32'h080);
    step(1);
    check("w4_valid_e9", 32'(res_valid), 32'd0);
    step(1);
    check("w4_valid_e10", 32'(res_valid), 32'd1);
    check("w4_result", 32'(result), 32'h2);
    check("w4_match", 32'(match_cnt), 32'd3);
    check("w4_trial", 32'(trial_cnt), 32'd4);
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;

    // Reset asserted in the middle of a window
    start = 1'b1; exp_label = 3'b100;
    step(1);
    start = 1'b0; spk_in = 3'b111;
    step(3);
    reset = 1'b1;
    #1;
    check("mrst_valid", 32'(res_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_cnt", 32'(dbg_cnt), 32'h000);
    check("mrst_overrun", 32'(overrun), 32'd0);
    check("mrst_match", 32'(match_cnt), 32'd0);
    check("mrst_trial", 32'(trial_cnt), 32'd0);
    spk_in = 3'b000;
    step(1);
    reset = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("post_rst_busy", 32'(busy), 32'd1);
    check("post_rst_state", 32'(dbg_state), 32'd1);

    // WIN_LEN=20 instance: neuron 3 counter saturates
    start2 = 1'b1; exp2 = 3'b001; spk2 = 3'b001;
    step(1);
    start2 = 1'b0; exp2 = 3'b000;
    step(20);
    spk2 = 3'b000;
    check("w20_cnt", 32'(cnt2), 32'h00F);
    step(1);
    check("w20_valid_e21", 32'(valid2), 32'd0);
    step(1);
    check("w20_valid_e22", 32'(valid2), 32'd1);
    check("w20_result", 32'(result2), 32'h1);
    check("w20_match", 32'(match2), 32'd1);
    check("w20_trial", 32'(trial2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
